wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-controller, one-peripheral Wishbone arbiter with a bus-timeout watchdog.
- Lets the instruction fetch bus and the data load/store bus share one memory/peripheral Wishbone port.
- Uses registered round-robin grants; a grant is held for the whole transaction.
- If the target never answers, the arbiter terminates the transaction with err so the requester cannot hang.

Parameters:
- TIMEOUT, 255, max cycles a granted transaction may wait for ack/err before forced err; legal range 1..65535
- CNT_W, $clog2(TIMEOUT+1), width of the watchdog counter (derived, not overridden)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- wb_c0  Wishbone.Peripheral  bundle  requester 0 (instruction bus): cyc, stb, we, sel[3:0], addr[31:0], data_wr[31:0] in; ack, err, data_rd[31:0] out
- wb_c1  Wishbone.Peripheral  bundle  requester 1 (data bus), same fields as wb_c0
- wb_t   Wishbone.Controller  bundle  shared target, same fields with directions reversed
- o_grant  output  2  one-hot current owner; 2'b00 = idle
- o_timeout  output  1  one-cycle pulse when the watchdog aborts a transaction

Behaviour:
- Reset: i_rst at a clock edge forces:
  - state IDLE, o_grant=00, o_timeout=0, watchdog=0, last_owner=1 (so c0 wins the first tie).
  - Combinationally with the state: wb_t.cyc/stb=0, both requesters' ack/err=0.
- Reset mid-transaction: the grant is dropped in the same cycle. A target ack arriving later is ignored, not forwarded.
- States: IDLE, OWN0, OWN1, ABORT.
- IDLE:
  - Sample wb_c0.cyc and wb_c1.cyc.
  - Only one asserted: go to that OWNx.
  - Both asserted: grant the one that is not last_owner.
  - Neither asserted: stay.
  - Latency: a request seen at edge N is granted from cycle N+1. Requesters hold cyc and addr stable while ungranted.
- OWNx:
  - wb_t.cyc/stb/we/sel/addr/data_wr = wb_cx fields, combinationally.
  - wb_cx.ack = wb_t.ack and wb_cx.err = wb_t.err, both combinational.
  - data_rd goes to both requesters unmuxed; ack/err go only to the owner.
  - On wb_t.ack or wb_t.err: last_owner<=x, go to IDLE. This gives a mandatory one-cycle bubble before the next grant.
  - Owner drops cyc without ack/err (abandoned cycle): go to IDLE, last_owner<=x.
  - Watchdog:
    - Cleared on entry to OWNx, increments every OWNx cycle without ack/err.
    - When it reaches TIMEOUT: go to ABORT.
    - ack and err arriving in the same cycle the watchdog hits TIMEOUT: ack/err wins, no abort.
- ABORT (exactly one cycle):
  - wb_t.cyc/stb=0.
  - Owner receives err=1, ack=0.
  - o_timeout=1.
  - last_owner<=x, then go to IDLE.
  - A late target ack in ABORT or IDLE is dropped.
- Non-owner requester: ack=0, err=0 at all times.
- o_grant is registered. It equals the one-hot state in OWNx/ABORT and 00 in IDLE.
- Target ack and err asserted together: forward both; the requester treats err as dominant.
- Counter never wraps: it saturates at TIMEOUT because the state leaves OWNx.

Decomposition:
- Shared package (bus_pkg):
  - arb_state_t enum {IDLE, OWN0, OWN1, ABORT}
  - WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4 constants
- One sub-module, wb_watchdog: counter with clear/enable/expire, parameterised by TIMEOUT. Reusable by the future peripheral crossbar.
- Muxing and the FSM stay in wb_arbiter2.

Test Plan:
- Single c0 read, target acks 2 cycles after stb, data_rd=32'hDEADBEEF:
  - o_grant=01 one cycle after c0.cyc.
  - c0 sees ack with DEADBEEF; c1 ack stays 0.
  - o_grant returns to 00 the cycle after ack.
- c0 and c1 assert cyc on the same cycle just after reset:
  - c0 granted first.
  - After its ack, one idle cycle, then c1 granted.
  - With both requesting continuously, grants alternate 01,00,10,00,01…
- c1 write with sel=4'b0011, addr=32'h0000_1004: wb_t shows we=1, sel=0011, addr/data_wr identical to c1 for the whole grant.
- TIMEOUT=4, target never acks:
  - Exactly 4 OWN cycles, then an ABORT cycle with c0.err=1, o_timeout=1, wb_t.cyc=0.
  - A late target ack 2 cycles later is not seen by any requester.
- i_rst asserted while OWN1 is waiting on the target:
  - Next cycle o_grant=00 and wb_t.cyc=0.
  - After reset, c0 wins a simultaneous request.
- Owner c1 drops cyc with no ack while c0 is requesting: one IDLE cycle, then o_grant=01.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared bus constants and arbiter state encoding for the Wishbone arbiter slice.
package wb_arbiter2_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1,
    StAbort
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter2_if.sv
// Classic Wishbone bundle; controller drives the cycle, peripheral answers it.
interface wb_if;
  import wb_arbiter2_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [WB_SEL_W-1:0]  sel;
  logic [WB_ADDR_W-1:0] addr;
  logic [WB_DATA_W-1:0] data_wr;
  logic                 ack;
  logic                 err;
  logic [WB_DATA_W-1:0] data_rd;

  modport controller (
    output cyc, stb, we, sel, addr, data_wr,
    input  ack, err, data_rd
  );

  modport peripheral (
    input  cyc, stb, we, sel, addr, data_wr,
    output ack, err, data_rd
  );

endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Bus watchdog: counts stalled cycles and flags the cycle whose increment reaches TIMEOUT.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the stalled cycle whose increment would land on TIMEOUT.
  assign o_expire = i_enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_arbiter2.sv
// Two-requester Wishbone arbiter: registered round-robin grant held per transaction,
// with a watchdog that terminates unanswered cycles with err.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  wb_if.peripheral   wb_c0,
  wb_if.peripheral   wb_c1,
  wb_if.controller   wb_t,
  output logic [1:0] o_grant,
  output logic       o_timeout
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;

  logic own0, own1, owned, in_abort, done;
  logic wd_clear, wd_enable, wd_expire;

  logic                 m_cyc, m_stb, m_we;
  logic [WB_SEL_W-1:0]  m_sel;
  logic [WB_ADDR_W-1:0] m_addr;
  logic [WB_DATA_W-1:0] m_data_wr;

  assign own0     = (state_q == StOwn0);
  assign own1     = (state_q == StOwn1);
  assign owned    = own0 | own1;
  assign in_abort = (state_q == StAbort);
  assign done     = wb_t.ack | wb_t.err;

  always_comb begin
    m_cyc     = wb_c0.cyc;
    m_stb     = wb_c0.stb;
    m_we      = wb_c0.we;
    m_sel     = wb_c0.sel;
    m_addr    = wb_c0.addr;
    m_data_wr = wb_c0.data_wr;
    if (own1) begin
      m_cyc     = wb_c1.cyc;
      m_stb     = wb_c1.stb;
      m_we      = wb_c1.we;
      m_sel     = wb_c1.sel;
      m_addr    = wb_c1.addr;
      m_data_wr = wb_c1.data_wr;
    end
  end

  assign wb_t.cyc     = owned & m_cyc;
  assign wb_t.stb     = owned & m_stb;
  assign wb_t.we      = owned & m_we;
  assign wb_t.sel     = owned ? m_sel : '0;
  assign wb_t.addr    = owned ? m_addr : '0;
  assign wb_t.data_wr = owned ? m_data_wr : '0;

  // Read data fans out unmuxed; only the qualifiers are steered to the owner.
  assign wb_c0.data_rd = wb_t.data_rd;
  assign wb_c1.data_rd = wb_t.data_rd;
  assign wb_c0.ack     = own0 & wb_t.ack;
  assign wb_c1.ack     = own1 & wb_t.ack;
  assign wb_c0.err     = (own0 & wb_t.err) | (in_abort & grant_q[0]);
  assign wb_c1.err     = (own1 & wb_t.err) | (in_abort & grant_q[1]);

  assign wd_clear  = ~owned;
  assign wd_enable = owned & m_cyc & ~done;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (wd_clear),
    .i_enable (wd_enable),
    .o_expire (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (wb_c0.cyc && wb_c1.cyc) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (wb_c0.cyc) begin
          state_d = StOwn0;
        end else if (wb_c1.cyc) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        // A real response beats a same-cycle watchdog expiry.
        if (done || !m_cyc) begin
          state_d = StIdle;
          last_d  = own1;
        end else if (wd_expire) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        state_d = StIdle;
        last_d  = grant_q[1];
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d = 2'b00;
    case (state_d)
      StOwn0:  grant_d = 2'b01;
      StOwn1:  grant_d = 2'b10;
      StAbort: grant_d = grant_q;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_timeout = in_abort;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized requesters and target against a transaction-level model of the arbiter.
module tb_wb_arbiter2;
  import wb_arbiter2_pkg::*;

  localparam int unsigned TO      = 4;
  localparam int          NCYCLES = 3000;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  always #5 i_clk = ~i_clk;

  wb_if c0_bus ();
  wb_if c1_bus ();
  wb_if t_bus ();

  wb_arbiter2 #(
    .TIMEOUT (TO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .wb_c0     (c0_bus),
    .wb_c1     (c1_bus),
    .wb_t      (t_bus),
    .o_grant   (grant),
    .o_timeout (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the bus, whether this is the abort cycle, stalled cycles, last owner.
  int m_owner;  // 0 none, 1 c0, 2 c1
  bit m_abort;
  int m_wait;
  int m_last;

  bit          r_cyc[2];
  bit          r_we[2];
  logic [3:0]  r_sel[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_dat[2];
  int          r_idle[2];
  bit          r_seen[2];

  int          t_cnt, t_lat, t_kind;
  bit          t_ack, t_err, t_cyc_now;
  logic [31:0] t_rd;

  task automatic drive_reqs();
    c0_bus.cyc = r_cyc[0]; c0_bus.stb = r_cyc[0]; c0_bus.we = r_we[0];
    c0_bus.sel = r_sel[0]; c0_bus.addr = r_addr[0]; c0_bus.data_wr = r_dat[0];
    c1_bus.cyc = r_cyc[1]; c1_bus.stb = r_cyc[1]; c1_bus.we = r_we[1];
    c1_bus.sel = r_sel[1]; c1_bus.addr = r_addr[1]; c1_bus.data_wr = r_dat[1];
  endtask

  task automatic new_target_txn();
    t_cnt  = 0;
    t_lat  = int'($urandom_range(0, 5));  // 4 and 5 never answer
    t_kind = int'($urandom_range(0, 5));  // 0..3 ack, 4 err, 5 ack+err
  endtask

  initial begin
    bit          own_ok, exp_tcyc, exp_ack0, exp_ack1, exp_err0, exp_err1;
    int          x;
    logic [1:0]  exp_grant;

    m_owner = 0; m_abort = 0; m_wait = 0; m_last = 1;
    for (int i = 0; i < 2; i++) begin
      r_cyc[i] = 0; r_we[i] = 0; r_sel[i] = '0; r_addr[i] = '0; r_dat[i] = '0;
      r_idle[i] = 0; r_seen[i] = 0;
    end
    drive_reqs();
    t_ack = 0; t_err = 0; t_rd = '0;
    t_bus.ack = 0; t_bus.err = 0; t_bus.data_rd = '0;
    new_target_txn();

    for (int c = 0; c < NCYCLES; c++) begin
      @(negedge i_clk);
      i_rst = (c < 2) || ($urandom_range(0, 149) == 0);

      own_ok = (m_owner != 0) && !m_abort;
      x      = (m_owner == 2) ? 1 : 0;

      for (int i = 0; i < 2; i++) begin
        if (r_cyc[i]) begin
          if (r_seen[i] ||
              (own_ok && x == i && $urandom_range(0, 29) == 0)) begin
            r_cyc[i]  = 0;
            r_idle[i] = int'($urandom_range(0, 3));
          end
        end else if (r_idle[i] == 0) begin
          r_cyc[i]  = 1;
          r_we[i]   = 1'($urandom);
          r_sel[i]  = 4'($urandom);
          r_addr[i] = $urandom;
          r_dat[i]  = $urandom;
        end else begin
          r_idle[i]--;
        end
      end
      drive_reqs();
      #1;

      t_cyc_now = t_bus.cyc;
      if (t_cyc_now && t_cnt == t_lat) begin
        t_ack = (t_kind != 4);
        t_err = (t_kind >= 4);
      end else begin
        t_ack = !t_cyc_now && ($urandom_range(0, 7) == 0);  // stray late ack
        t_err = 0;
      end
      t_rd          = $urandom;
      t_bus.ack     = t_ack;
      t_bus.err     = t_err;
      t_bus.data_rd = t_rd;
      #1;

      exp_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      exp_tcyc  = own_ok ? r_cyc[x] : 1'b0;
      exp_ack0  = own_ok && x == 0 && t_ack;
      exp_ack1  = own_ok && x == 1 && t_ack;
      exp_err0  = (own_ok && x == 0 && t_err) || (m_abort && m_owner == 1);
      exp_err1  = (own_ok && x == 1 && t_err) || (m_abort && m_owner == 2);

      check("grant",   grant,          exp_grant);
      check("timeout", timeout,        m_abort);
      check("t_cyc",   t_bus.cyc,      exp_tcyc);
      check("t_stb",   t_bus.stb,      exp_tcyc);
      check("c0_ack",  c0_bus.ack,     exp_ack0);
      check("c0_err",  c0_bus.err,     exp_err0);
      check("c1_ack",  c1_bus.ack,     exp_ack1);
      check("c1_err",  c1_bus.err,     exp_err1);
      check("c0_rd",   c0_bus.data_rd, t_rd);
      check("c1_rd",   c1_bus.data_rd, t_rd);
      if (exp_tcyc) begin
        check("t_we",   t_bus.we,      r_we[x]);
        check("t_sel",  t_bus.sel,     r_sel[x]);
        check("t_addr", t_bus.addr,    r_addr[x]);
        check("t_dat",  t_bus.data_wr, r_dat[x]);
      end
      r_seen[0] = c0_bus.ack | c0_bus.err;
      r_seen[1] = c1_bus.ack | c1_bus.err;

      @(posedge i_clk);
      if (i_rst) begin
        m_owner = 0; m_abort = 0; m_wait = 0; m_last = 1;
      end else if (m_abort) begin
        m_last  = m_owner - 1;
        m_owner = 0;
        m_abort = 0;
      end else if (m_owner != 0) begin
        if (t_ack || t_err || !r_cyc[x]) begin
          m_last  = x;
          m_owner = 0;
        end else begin
          m_wait++;
          if (m_wait == int'(TO)) m_abort = 1;
        end
      end else begin
        m_wait = 0;
        if (r_cyc[0] && r_cyc[1]) m_owner = (m_last == 0) ? 2 : 1;
        else if (r_cyc[0])        m_owner = 1;
        else if (r_cyc[1])        m_owner = 2;
      end

      if (t_cyc_now && !(t_ack || t_err)) t_cnt++;
      else if (t_cyc_now || t_cnt != 0)   new_target_txn();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
